shape_encoder_7b_to_3b: RTL
===========================

// Module: shape_encoder_7b_to_3b
// PURPOSE
//  Inverse of the 3b->7b shape decoder. Accepts 7-bit active-low segment patterns, e.g. an object leaving
//  the last digit of the object shifter, and recovers the 3-bit shape code.
//  Classifies each pattern as MATCH, BLANK or ILLEGAL.
//  Ready/valid on both sides with a 2-entry output buffer. Feeds scoring/collision logic with shape IDs.
// PARAMETERS
//  CNT_W   8   width of the saturating illegal-pattern counter
// PORTS
//  Clk           in   1      system clock; single clock domain
//  Rst           in   1      synchronous reset, active-high
//  ShapeIn       in   7      segment pattern {g..a}, active-low (0 = lit)
//  ShapeInValid  in   1      ShapeIn holds a pattern
//  ShapeInReady  out  1      block can accept; transfer when Valid&Ready on a rising Clk
//  CodeOut       out  3      recovered shape code
//  CodeKind      out  2      00 MATCH, 01 BLANK, 10 ILLEGAL (11 unused)
//  CodeValid     out  1      CodeOut/CodeKind valid
//  CodeReady     in   1      downstream accepts; beat retires when Valid&Ready
//  IllegalCount  out  CNT_W  number of ILLEGAL patterns accepted; saturates at all-ones
//  IllegalSeen   out  1      sticky; set by first accepted ILLEGAL, cleared only by Rst
// BEHAVIOUR
//  Table (code: pattern): 0:0011100 1:0011110 2:1011110 3:1011111 4:0100011 5:0110011 6:1110011 7:1101111
//  - Exact 7-bit match -> MATCH, CodeOut = code.
//  - 1111111 -> BLANK, CodeOut = 0.
//  - Anything else -> ILLEGAL, CodeOut = 0.
//  Buffer FSM, states EMPTY/ONE/TWO:
//  - push = ShapeInValid&ShapeInReady; pop = CodeValid&CodeReady.
//  - EMPTY: push->ONE.
//  - ONE: push&!pop->TWO; pop&!push->EMPTY; push&pop->ONE.
//  - TWO: pop->ONE. Push is impossible because Ready is 0.
//  ShapeInReady = (state != TWO), driven from a register; no combinational path from CodeReady.
//  CodeValid = (state != EMPTY). Head-of-queue outputs are registered.
//  Latency: a push in cycle N gives CodeValid=1 in cycle N+1 when the buffer was EMPTY. Throughput is 1 beat/cycle.
//  Order is preserved. Held head data is stable while CodeValid&!CodeReady.
//  IllegalCount increments on the push of an ILLEGAL pattern. It holds at 2^CNT_W-1.
//  Count/sticky update is independent of the downstream stall.
//  Rst, including mid-transfer:
//  - next cycle: state EMPTY, ShapeInReady=1, CodeValid=0, CodeOut=0, CodeKind=00, IllegalCount=0, IllegalSeen=0.
//  - Buffered beats are discarded. Inputs sampled in the Rst cycle are ignored.
//  ShapeIn is don't-care while ShapeInValid=0. X on ShapeIn with Valid=1 is a bench error.
// CONFIGURATION
//  SHAPE_ENC_BLANK_DROP_EN defined:
//  - BLANK patterns are consumed (Ready honoured) but never enter the buffer.
//  - No output beat, state unchanged by that push.
//  - CodeKind never shows 01.
//  Not defined (default): BLANK is forwarded as a normal beat with CodeKind=01.
// STRUCTURE
//  Package shape_pkg:
//  - SHAPE_W=7, CODE_W=3.
//  - SHAPE_TABLE[8] constants (shared with the decoder).
//  - SHAPE_BLANK=7'b1111111.
//  - KIND_MATCH/KIND_BLANK/KIND_ILLEGAL localparams.
//  - buffer state encodings BUF_EMPTY/BUF_ONE/BUF_TWO.
//  Sub-module shape_match_lut: purely combinational, ShapeIn -> {code, kind}.
//  Top holds the 2-entry buffer FSM, counter and sticky flag.
// TESTING
//  1 Rst, then push 0011100, 0100011, 1101111 back-to-back, CodeReady=1 -> codes 0,4,7 MATCH on cycles 1,2,3; Ready stays 1
//  2 CodeReady=0, push 1011110 then 1110011 -> Ready drops after 2nd push; head holds 2/MATCH; release -> 2 then 6 in order
//  3 Push 0000000 -> CodeKind=10, CodeOut=0, IllegalCount=1, IllegalSeen=1
//    Push 255+ illegals with CNT_W=8 -> count sticks at 255
//  4 Push 1111111 -> default build: beat kind 01 code 0
//    BLANK_DROP_EN build: no CodeValid, push accepted (Ready=1)
//  5 Buffer TWO with CodeReady=0, assert Rst 1 cycle -> CodeValid=0, Ready=1, counters 0; old beats never appear
//  6 Random valid/ready stalls over 10k patterns vs scoreboard of the table -> no loss, duplication or reorder

Source files
------------

// File: rtl/shape_pkg.sv
// Shared shape constants: segment table for the 3b<->7b shape codec, kind codes, buffer states.
package shape_pkg;
    localparam int SHAPE_W = 7;
    localparam int CODE_W  = 3;
    localparam int KIND_W  = 2;

    // Active-low segment patterns {g..a}, indexed by shape code
    localparam logic [SHAPE_W-1:0] SHAPE_TABLE [8] = '{
        7'b0011100, 7'b0011110, 7'b1011110, 7'b1011111,
        7'b0100011, 7'b0110011, 7'b1110011, 7'b1101111
    };

    localparam logic [SHAPE_W-1:0] SHAPE_BLANK = 7'b1111111;

    localparam logic [KIND_W-1:0] KIND_MATCH   = 2'b00;
    localparam logic [KIND_W-1:0] KIND_BLANK   = 2'b01;
    localparam logic [KIND_W-1:0] KIND_ILLEGAL = 2'b10;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;
endpackage

// File: rtl/shape_match_lut.sv
// Combinational reverse lookup: 7-bit active-low segment pattern -> {code, kind}.
// Unknown patterns report ILLEGAL with code 0; all-dark reports BLANK with code 0.
module shape_match_lut
    import shape_pkg::*;
(
    input  logic [SHAPE_W-1:0] shape,
    output logic [CODE_W-1:0]  code,
    output logic [KIND_W-1:0]  kind
);

    always_comb begin
        code = '0;
        kind = KIND_ILLEGAL;
        if (shape == SHAPE_BLANK) begin
            kind = KIND_BLANK;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (shape == SHAPE_TABLE[i]) begin
                    code = CODE_W'(i);
                    kind = KIND_MATCH;
                end
            end
        end
    end

endmodule

// File: rtl/shape_encoder_7b_to_3b.sv
// Shape encoder: classifies segment patterns and queues {code, kind} in a 2-entry registered buffer.
// Build option SHAPE_ENC_BLANK_DROP_EN: BLANK patterns are accepted but never produce an output beat.
module shape_encoder_7b_to_3b
    import shape_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [SHAPE_W-1:0]  ShapeIn,
    input  logic                ShapeInValid,
    output logic                ShapeInReady,
    output logic [CODE_W-1:0]   CodeOut,
    output logic [KIND_W-1:0]   CodeKind,
    output logic                CodeValid,
    input  logic                CodeReady,
    output logic [CNT_W-1:0]    IllegalCount,
    output logic                IllegalSeen
);

    logic [CODE_W-1:0] lut_code;
    logic [KIND_W-1:0] lut_kind;
    logic [CODE_W-1:0] tail_code;
    logic [KIND_W-1:0] tail_kind;
    logic              push;
    logic              pop;
    logic              keep;
    buf_state_t        state;

    shape_match_lut u_lut (
        .shape (ShapeIn),
        .code  (lut_code),
        .kind  (lut_kind)
    );

    assign push = ShapeInValid & ShapeInReady;
    assign pop  = CodeValid & CodeReady;

`ifdef SHAPE_ENC_BLANK_DROP_EN
    // Dropped blanks still complete the input handshake but leave the buffer untouched
    assign keep = push && (lut_kind != KIND_BLANK);
`else
    assign keep = push;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= BUF_EMPTY;
            ShapeInReady <= 1'b1;
            CodeValid    <= 1'b0;
            CodeOut      <= '0;
            CodeKind     <= KIND_MATCH;
            tail_code    <= '0;
            tail_kind    <= KIND_MATCH;
            IllegalCount <= '0;
            IllegalSeen  <= 1'b0;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (keep) begin
                        CodeOut   <= lut_code;
                        CodeKind  <= lut_kind;
                        CodeValid <= 1'b1;
                        state     <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (keep && !pop) begin
                        tail_code    <= lut_code;
                        tail_kind    <= lut_kind;
                        ShapeInReady <= 1'b0;
                        state        <= BUF_TWO;
                    end else if (pop && !keep) begin
                        CodeValid <= 1'b0;
                        state     <= BUF_EMPTY;
                    end else if (keep && pop) begin
                        CodeOut  <= lut_code;
                        CodeKind <= lut_kind;
                    end
                end
                BUF_TWO: begin
                    if (pop) begin
                        CodeOut      <= tail_code;
                        CodeKind     <= tail_kind;
                        ShapeInReady <= 1'b1;
                        state        <= BUF_ONE;
                    end
                end
                default: begin
                    state        <= BUF_EMPTY;
                    ShapeInReady <= 1'b1;
                    CodeValid    <= 1'b0;
                end
            endcase

            if (push && lut_kind == KIND_ILLEGAL) begin
                IllegalSeen <= 1'b1;
                if (IllegalCount != {CNT_W{1'b1}})
                    IllegalCount <= IllegalCount + 1'b1;
            end
        end
    end

endmodule
